shape_view_controller: RTL

Sequences the shape renderers (diamond and sibling object blocks) on the VGA display. Takes three push-buttons and the vertical sync, and drives a one-hot shape select plus the full-screen flag that every object renderer consumes. All mode and selection changes are applied only at a frame boundary, so no frame is drawn with mixed settings. It also provides a timed auto-cycle slideshow.

---
 rtl/shape_view_pkg.sv | 22 ++
 rtl/shape_view_controller_if.sv | 23 ++
 rtl/button_debouncer.sv | 62 ++++++
 rtl/shape_view_controller.sv | 134 +++++++++++++
 4 files changed

// File: rtl/shape_view_pkg.sv
// Shared definitions for the shape view controller: view states,
// default parameter values and the select-index width helper.
package shape_view_pkg;

    typedef enum logic [1:0] {
        SPLIT = 2'd0,
        FULL  = 2'd1,
        AUTO  = 2'd2
    } view_state_e;

    localparam int DEFAULT_NUM_SHAPES      = 3;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_AUTO_FRAMES     = 120;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int index_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/shape_view_controller_if.sv
// Button, vsync and view-select signals exchanged between the
// controller and its environment.
interface shape_view_controller_if #(
    parameter int NUM_SHAPES = shape_view_pkg::DEFAULT_NUM_SHAPES
);
    logic                  btn_next;
    logic                  btn_mode;
    logic                  btn_auto;
    logic                  vsync_n;
    logic [NUM_SHAPES-1:0] shape_select;
    logic                  full_screen;
    logic                  auto_active;

    modport master (
        output btn_next, btn_mode, btn_auto, vsync_n,
        input  shape_select, full_screen, auto_active
    );

    modport slave (
        input  btn_next, btn_mode, btn_auto, vsync_n,
        output shape_select, full_screen, auto_active
    );
endinterface

// File: rtl/button_debouncer.sv
// Synchronises a raw push-button, accepts a new level only after it has
// been stable for DEBOUNCE_CYCLES clocks, and emits a one-cycle pulse on
// each accepted press (rising edge of the debounced level).
module button_debouncer
    import shape_view_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int CNT_W = index_width(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounced level, stability counter and press pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/shape_view_controller.sv
// Chooses which shape renderer is shown and whether it fills the screen.
// Button presses are latched as pending requests and only applied on a
// vsync frame boundary, so every frame is drawn with one consistent setting.
module shape_view_controller
    import shape_view_pkg::*;
#(
    parameter int NUM_SHAPES      = DEFAULT_NUM_SHAPES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int AUTO_FRAMES     = DEFAULT_AUTO_FRAMES
) (
    input logic                    clk,
    input logic                    reset_n,
    shape_view_controller_if.slave bus
);
    localparam int IDX_W  = index_width(NUM_SHAPES);
    localparam int FCNT_W = index_width(AUTO_FRAMES);

    logic pressNext, pressMode, pressAuto;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk(clk), .rst_n(reset_n), .btn_i(bus.btn_next), .pulse_o(pressNext)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk(clk), .rst_n(reset_n), .btn_i(bus.btn_mode), .pulse_o(pressMode)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auto_db (
        .clk(clk), .rst_n(reset_n), .btn_i(bus.btn_auto), .pulse_o(pressAuto)
    );

    logic vsync1_q, vsync2_q, vsync3_q;
    logic frameTick;

    // Synchronise vsync (idle high) and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync1_q <= 1'b1;
            vsync2_q <= 1'b1;
            vsync3_q <= 1'b1;
        end else begin
            vsync1_q <= bus.vsync_n;
            vsync2_q <= vsync1_q;
            vsync3_q <= vsync2_q;
        end
    end

    assign frameTick = vsync3_q & ~vsync2_q;

    view_state_e           state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [FCNT_W-1:0]     frameCnt_q, frameCnt_d;
    logic                  pendNext_q, pendNext_d;
    logic                  pendMode_q, pendMode_d;
    logic                  pendAuto_q, pendAuto_d;
    logic [NUM_SHAPES-1:0] select_q, select_d;
    logic                  fullScreen_q, fullScreen_d;
    logic                  autoActive_q, autoActive_d;
    logic                  lastFrame, advance;

    // Frame-boundary update: mode beats auto, index steps at most once per tick,
    // presses arriving on the tick itself are kept for the following tick.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        frameCnt_d = frameCnt_q;
        pendNext_d = pendNext_q | pressNext;
        pendMode_d = pendMode_q | pressMode;
        pendAuto_d = pendAuto_q | pressAuto;
        lastFrame  = (state_q == AUTO) && (frameCnt_q == FCNT_W'(AUTO_FRAMES - 1));
        advance    = 1'b0;

        if (frameTick) begin
            pendNext_d = pressNext;
            pendMode_d = pressMode;
            pendAuto_d = pressAuto;

            if (pendMode_q) begin
                case (state_q)
                    SPLIT:   state_d = FULL;
                    default: state_d = SPLIT;
                endcase
            end else if (pendAuto_q) begin
                case (state_q)
                    AUTO:    state_d = FULL;
                    default: state_d = AUTO;
                endcase
            end

            advance = pendNext_q | lastFrame;
            if (advance) begin
                index_d = (index_q == IDX_W'(NUM_SHAPES - 1)) ? '0 : index_q + 1'b1;
            end

            if ((state_q != AUTO) || (state_d != AUTO) || advance) begin
                frameCnt_d = '0;
            end else begin
                frameCnt_d = frameCnt_q + 1'b1;
            end
        end

        select_d     = NUM_SHAPES'(1) << index_d;
        fullScreen_d = (state_d != SPLIT);
        autoActive_d = (state_d == AUTO);
    end

    // View state, index, frame counter, pending requests and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SPLIT;
            index_q      <= '0;
            frameCnt_q   <= '0;
            pendNext_q   <= 1'b0;
            pendMode_q   <= 1'b0;
            pendAuto_q   <= 1'b0;
            select_q     <= NUM_SHAPES'(1);
            fullScreen_q <= 1'b0;
            autoActive_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            frameCnt_q   <= frameCnt_d;
            pendNext_q   <= pendNext_d;
            pendMode_q   <= pendMode_d;
            pendAuto_q   <= pendAuto_d;
            select_q     <= select_d;
            fullScreen_q <= fullScreen_d;
            autoActive_q <= autoActive_d;
        end
    end

    assign bus.shape_select = select_q;
    assign bus.full_screen  = fullScreen_q;
    assign bus.auto_active  = autoActive_q;

endmodule
